// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//   Recovers pixel coordinates from a VGA-style stream (active-low HS/VS plus 12-bit RGB),
//   validates line/frame timing and declares lock after LOCK_FRAMES consecutive good frames.
//   All sampling and counting happen only on i_clk edges with i_pix_stb=1.
//
// Optional feature: define VGA_SYNC_DECODER_CHECKSUM_EN to build a 16-bit per-frame sum of
//   i_rgb over locked active pixels. Without it o_checksum/o_checksum_vld are tied to 0.
//
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_pix_stb         pixel strobe (qualifies every sample)
//   i_hs, i_vs        horizontal / vertical sync, active-low
//   i_rgb             pixel {R,G,B} 4 bits each
//   o_x, o_y          recovered column / row (held outside the active area)
//   o_de, o_rgb       data enable (locked + active) and registered pixel
//   o_sof             pulse at the first active pixel of a locked frame
//   o_locked, o_err   lock indicator, single-clock timing-violation pulse
//   o_checksum(_vld)  frame checksum and its update pulse
module vga_sync_decoder #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_stb,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic [11:0] i_rgb,
  output logic [9:0]  o_x,
  output logic [8:0]  o_y,
  output logic        o_de,
  output logic [11:0] o_rgb,
  output logic        o_sof,
  output logic        o_locked,
  output logic        o_err,
  output logic [15:0] o_checksum,
  output logic        o_checksum_vld
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned H_START = H_SYNC + H_BP;
  localparam int unsigned V_START = V_SYNC + V_BP;
  localparam int unsigned GOOD_W  = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES + 1) : 1;

  typedef enum logic [1:0] {StSearch, StTrack, StLocked} state_e;

  state_e            state_q, state_d;
  logic              hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic              vs_pend_q, vs_pend_d;
  logic [9:0]        h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [9:0]        hs_w_q, hs_w_d, vs_w_q, vs_w_d;
  logic [GOOD_W-1:0] good_q, good_d, good_inc;
  logic [9:0]        x_q, x_d;
  logic [8:0]        y_q, y_d;
  logic [11:0]       rgb_q, rgb_d;
  logic              de_q, de_d, sof_q, sof_d, err_q, err_d;

  logic              hs_fall, hs_rise, vs_fall, vs_rise;
  logic              line_fail, frame_fail, fail, active, pix_de;
  logic [9:0]        h_inc, v_inc, h_pos, v_pos, x_val;
  logic [8:0]        y_val;

  // Position of the pixel sampled on this strobe (counter value after the update).
  always_comb begin
    hs_fall = i_pix_stb & hs_prev_q & ~i_hs;
    hs_rise = i_pix_stb & ~hs_prev_q & i_hs;
    vs_fall = i_pix_stb & vs_prev_q & ~i_vs;
    vs_rise = i_pix_stb & ~vs_prev_q & i_vs;
    h_inc   = (h_cnt_q == 10'd1023) ? h_cnt_q : h_cnt_q + 10'd1;
    v_inc   = (v_cnt_q == 10'd1023) ? v_cnt_q : v_cnt_q + 10'd1;
    h_pos   = hs_fall ? 10'd0 : h_inc;
    v_pos   = v_cnt_q;
    if (hs_fall) begin
      // First hs fall at or after a vs fall starts line 0.
      v_pos = (vs_pend_q | vs_fall) ? 10'd0 : v_inc;
    end
    active  = (h_pos >= 10'(H_START)) && (h_pos < 10'(H_START + H_ACTIVE)) &&
              (v_pos >= 10'(V_START)) && (v_pos < 10'(V_START + V_ACTIVE));
    x_val   = h_pos - 10'(H_START);
    y_val   = 9'(v_pos - 10'(V_START));
    // hs_w/vs_w hold the position where the sync pulse ended, i.e. its low width.
    line_fail  = hs_fall & ((h_cnt_q != 10'(H_TOTAL - 1)) | (hs_w_q != 10'(H_SYNC)));
    frame_fail = vs_fall & ((v_cnt_q != 10'(V_TOTAL - 1)) | (vs_w_q != 10'(V_SYNC)));
    fail       = (state_q != StSearch) & (line_fail | frame_fail);
    pix_de     = i_pix_stb & (state_q == StLocked) & active & ~fail;
  end

  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    good_inc  = good_q + GOOD_W'(1);
    hs_prev_d = i_pix_stb ? i_hs : hs_prev_q;
    vs_prev_d = i_pix_stb ? i_vs : vs_prev_q;
    vs_pend_d = hs_fall ? 1'b0 : (vs_fall ? 1'b1 : vs_pend_q);
    h_cnt_d   = i_pix_stb ? h_pos : h_cnt_q;
    v_cnt_d   = i_pix_stb ? v_pos : v_cnt_q;
    hs_w_d    = hs_rise ? h_pos : hs_w_q;
    vs_w_d    = vs_rise ? v_pos : vs_w_q;
    x_d       = (i_pix_stb & active) ? x_val : x_q;
    y_d       = (i_pix_stb & active) ? y_val : y_q;
    rgb_d     = (i_pix_stb & active) ? i_rgb : rgb_q;
    de_d      = i_pix_stb ? pix_de : de_q;
    sof_d     = pix_de & (x_val == 10'd0) & (y_val == 9'd0);
    err_d     = fail;

    case (state_q)
      StSearch: begin
        if (vs_fall) begin
          state_d = StTrack;
          good_d  = '0;
        end
      end
      StTrack: begin
        if (fail) begin
          state_d = StSearch;
        end else if (vs_fall) begin
          good_d = good_inc;
          if (good_inc == GOOD_W'(LOCK_FRAMES)) state_d = StLocked;
        end
      end
      StLocked: begin
        if (fail) state_d = StSearch;
      end
      default: state_d = StSearch;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StSearch;
      good_q    <= '0;
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      vs_pend_q <= 1'b0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      hs_w_q    <= '0;
      vs_w_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      rgb_q     <= '0;
      de_q      <= 1'b0;
      sof_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      good_q    <= good_d;
      hs_prev_q <= hs_prev_d;
      vs_prev_q <= vs_prev_d;
      vs_pend_q <= vs_pend_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      hs_w_q    <= hs_w_d;
      vs_w_q    <= vs_w_d;
      x_q       <= x_d;
      y_q       <= y_d;
      rgb_q     <= rgb_d;
      de_q      <= de_d;
      sof_q     <= sof_d;
      err_q     <= err_d;
    end
  end

  assign o_x      = x_q;
  assign o_y      = y_q;
  assign o_rgb    = rgb_q;
  assign o_de     = de_q;
  assign o_sof    = sof_q;
  assign o_err    = err_q;
  assign o_locked = (state_q == StLocked);

`ifdef VGA_SYNC_DECODER_CHECKSUM_EN
  logic [15:0] sum_q, sum_d, cks_q, cks_d, sum_next;
  logic        vld_q, vld_d, last_pix;

  // The sum restarts with the first active pixel of each locked frame.
  always_comb begin
    sum_next = (sof_d ? 16'd0 : sum_q) + {4'd0, i_rgb};
    last_pix = pix_de & (x_val == 10'(H_ACTIVE - 1)) & (y_val == 9'(V_ACTIVE - 1));
    sum_d    = pix_de ? sum_next : sum_q;
    cks_d    = last_pix ? sum_next : cks_q;
    vld_d    = last_pix;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sum_q <= '0;
      cks_q <= '0;
      vld_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      cks_q <= cks_d;
      vld_q <= vld_d;
    end
  end

  assign o_checksum     = cks_q;
  assign o_checksum_vld = vld_q;
`else
  assign o_checksum     = 16'd0;
  assign o_checksum_vld = 1'b0;
`endif

endmodule
